// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with sync clear, parallel load, wrap/saturate and boundary flags.
// Latency: 1 cycle from control sample to saida/evt; at_max/at_min are combinational from saida.
// Backpressure: none; every control input is acted on at each rising edge of clk.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   clr                  sync clear to RESET_VAL (highest priority)
//   load, load_val       sync parallel load, value clamped to [MIN_VAL, MAX_VAL]
//   acrescer, decrecer   count up / down by STEP; both or neither high holds
//   saida                registered count
//   at_max, at_min       saida sits on MAX_VAL / MIN_VAL
//   evt                  registered pulse: the value in saida was produced by a wrap or clamp
//   ovf_sticky,
//   unf_sticky           sticky upper/lower bound events (only with UDC_STICKY_FLAGS_EN)
//
// Optional feature: define UDC_STICKY_FLAGS_EN to add the ovf_sticky/unf_sticky ports and logic.
module updown_counter_param #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = 'h6A,
   parameter logic [WIDTH-1:0] MIN_VAL   = '0,
   parameter logic [WIDTH-1:0] MAX_VAL   = '1,
   parameter logic [WIDTH-1:0] STEP      = 1,
   parameter int               SATURATE  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             acrescer,
   input  logic             decrecer,
   output logic [WIDTH-1:0] saida,
   output logic             at_max,
   output logic             at_min,
   output logic             evt
`ifdef UDC_STICKY_FLAGS_EN
   ,
   output logic             ovf_sticky,
   output logic             unf_sticky
`endif
);

   // All bound arithmetic is carried one bit wider so saida+STEP cannot wrap silently.
   localparam logic [WIDTH:0] MIN_E      = {1'b0, MIN_VAL};
   localparam logic [WIDTH:0] MAX_E      = {1'b0, MAX_VAL};
   localparam logic [WIDTH:0] STEP_E     = {1'b0, STEP};
   localparam logic [WIDTH:0] DOWN_FLOOR = MIN_E + STEP_E;

   logic [WIDTH:0]   up_sum;
   logic             up_ok;
   logic             down_ok;
   logic             ld_above;
   logic             ld_below;
   logic [WIDTH-1:0] cnt_nxt;
   logic             hit_hi;
   logic             hit_lo;

   assign up_sum  = {1'b0, saida} + STEP_E;
   assign up_ok   = (up_sum <= MAX_E);
   assign down_ok = ({1'b0, saida} >= DOWN_FLOOR);

   // A bound at the edge of the WIDTH range can never be crossed by load_val;
   // tie the flag off instead of building a comparison that is always false.
   if (MAX_VAL == '1) begin : g_max_full
      assign ld_above = 1'b0;
   end else begin : g_max_cmp
      assign ld_above = ({1'b0, load_val} > MAX_E);
   end

   if (MIN_VAL == '0) begin : g_min_zero
      assign ld_below = 1'b0;
   end else begin : g_min_cmp
      assign ld_below = ({1'b0, load_val} < MIN_E);
   end

   // hit_hi / hit_lo mark an upper / lower bound event on this update; evt is their OR.
   always_comb begin
      cnt_nxt = saida;
      hit_hi  = 1'b0;
      hit_lo  = 1'b0;
      if (clr) begin
         cnt_nxt = RESET_VAL;
      end else if (load) begin
         if (ld_above) begin
            cnt_nxt = MAX_VAL;
            hit_hi  = 1'b1;
         end else if (ld_below) begin
            cnt_nxt = MIN_VAL;
            hit_lo  = 1'b1;
         end else begin
            cnt_nxt = load_val;
         end
      end else if (acrescer && !decrecer) begin
         if (up_ok) begin
            cnt_nxt = up_sum[WIDTH-1:0];
         end else begin
            cnt_nxt = (SATURATE != 0) ? MAX_VAL : MIN_VAL;
            hit_hi  = 1'b1;
         end
      end else if (decrecer && !acrescer) begin
         if (down_ok) begin
            cnt_nxt = saida - STEP;
         end else begin
            cnt_nxt = (SATURATE != 0) ? MIN_VAL : MAX_VAL;
            hit_lo  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         saida      <= RESET_VAL;
         evt        <= 1'b0;
`ifdef UDC_STICKY_FLAGS_EN
         ovf_sticky <= 1'b0;
         unf_sticky <= 1'b0;
`endif
      end else begin
         saida      <= cnt_nxt;
         evt        <= hit_hi | hit_lo;
`ifdef UDC_STICKY_FLAGS_EN
         if (clr) begin
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
         end else begin
            ovf_sticky <= ovf_sticky | hit_hi;
            unf_sticky <= unf_sticky | hit_lo;
         end
`endif
      end
   end

   assign at_max = (saida == MAX_VAL);
   assign at_min = (saida == MIN_VAL);

endmodule

// File: tb/tb_updown_counter_param.sv
// Testbench for updown_counter_param: three instances (default wrap, saturating,
// narrowed range 10..20 step 4) share the same stimulus; each is compared every
// cycle against an integer reference model, plus fixed expected-value sequences.
module tb_updown_counter_param;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clr;
   logic            load;
   logic [7:0]      load_val;
   logic            acrescer;
   logic            decrecer;
   logic [2:0][7:0] cnt_o;
   logic [2:0]      evt_o;
   logic [2:0]      amax_o;
   logic [2:0]      amin_o;
`ifdef UDC_STICKY_FLAGS_EN
   logic [2:0]      ovf_o;
   logic [2:0]      unf_o;
`endif

   always #5 clk = ~clk;

   updown_counter_param u_dflt (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
      .acrescer(acrescer), .decrecer(decrecer), .saida(cnt_o[0]),
      .at_max(amax_o[0]), .at_min(amin_o[0]), .evt(evt_o[0])
`ifdef UDC_STICKY_FLAGS_EN
      , .ovf_sticky(ovf_o[0]), .unf_sticky(unf_o[0])
`endif
   );

   updown_counter_param #(.SATURATE(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
      .acrescer(acrescer), .decrecer(decrecer), .saida(cnt_o[1]),
      .at_max(amax_o[1]), .at_min(amin_o[1]), .evt(evt_o[1])
`ifdef UDC_STICKY_FLAGS_EN
      , .ovf_sticky(ovf_o[1]), .unf_sticky(unf_o[1])
`endif
   );

   updown_counter_param #(.RESET_VAL(8'd12), .MIN_VAL(8'd10), .MAX_VAL(8'd20), .STEP(8'd4)) u_rng (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
      .acrescer(acrescer), .decrecer(decrecer), .saida(cnt_o[2]),
      .at_max(amax_o[2]), .at_min(amin_o[2]), .evt(evt_o[2])
`ifdef UDC_STICKY_FLAGS_EN
      , .ovf_sticky(ovf_o[2]), .unf_sticky(unf_o[2])
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: per-instance bounds and state as plain integers.
   int p_min [3];
   int p_max [3];
   int p_step[3];
   int p_rv  [3];
   bit p_sat [3];
   int m_cnt [3];
   bit m_evt [3];
   bit m_ovf [3];
   bit m_unf [3];

   typedef struct {
      bit         c;
      bit         l;
      logic [7:0] lv;
      bit         u;
      bit         d;
      logic [7:0] exp_cnt;
      bit         exp_evt;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = p_rv[i];
         m_evt[i] = 1'b0;
         m_ovf[i] = 1'b0;
         m_unf[i] = 1'b0;
      end
   endfunction

   // Next state from the rules: clear, then clamped load, then +/-STEP with
   // the out-of-range result replaced by the wrap target or the clamp value.
   function automatic void model_step();
      int n;
      for (int i = 0; i < 3; i++) begin
         m_evt[i] = 1'b0;
         if (clr) begin
            m_cnt[i] = p_rv[i];
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
         end else if (load) begin
            n = int'(load_val);
            if (n > p_max[i]) begin
               m_cnt[i] = p_max[i]; m_evt[i] = 1'b1; m_ovf[i] = 1'b1;
            end else if (n < p_min[i]) begin
               m_cnt[i] = p_min[i]; m_evt[i] = 1'b1; m_unf[i] = 1'b1;
            end else begin
               m_cnt[i] = n;
            end
         end else if (acrescer != decrecer) begin
            n = acrescer ? m_cnt[i] + p_step[i] : m_cnt[i] - p_step[i];
            if (n > p_max[i]) begin
               m_cnt[i] = p_sat[i] ? p_max[i] : p_min[i]; m_evt[i] = 1'b1; m_ovf[i] = 1'b1;
            end else if (n < p_min[i]) begin
               m_cnt[i] = p_sat[i] ? p_min[i] : p_max[i]; m_evt[i] = 1'b1; m_unf[i] = 1'b1;
            end else begin
               m_cnt[i] = n;
            end
         end
      end
   endfunction

   task automatic check_all();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("cnt[%0d]", i), 32'(cnt_o[i]), 32'(m_cnt[i]));
         chk($sformatf("evt[%0d]", i), 32'(evt_o[i]), 32'(m_evt[i]));
         chk($sformatf("at_max[%0d]", i), 32'(amax_o[i]), 32'(m_cnt[i] == p_max[i]));
         chk($sformatf("at_min[%0d]", i), 32'(amin_o[i]), 32'(m_cnt[i] == p_min[i]));
`ifdef UDC_STICKY_FLAGS_EN
         chk($sformatf("ovf[%0d]", i), 32'(ovf_o[i]), 32'(m_ovf[i]));
         chk($sformatf("unf[%0d]", i), 32'(unf_o[i]), 32'(m_unf[i]));
`endif
      end
   endtask

   task automatic apply(input bit c, input bit l, input logic [7:0] lv, input bit u, input bit d);
      clr      = c;
      load     = l;
      load_val = lv;
      acrescer = u;
      decrecer = d;
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      p_min  = '{0, 0, 10};
      p_max  = '{255, 255, 20};
      p_step = '{1, 1, 4};
      p_rv   = '{106, 106, 12};
      p_sat  = '{1'b0, 1'b1, 1'b0};

      //          clr load lv     up dn  exp    evt   (default instance)
      vecs[0]  = '{0, 0, 8'h00, 1, 0, 8'h6B, 1'b0};
      vecs[1]  = '{0, 0, 8'h00, 1, 1, 8'h6B, 1'b0};
      vecs[2]  = '{0, 0, 8'h00, 1, 1, 8'h6B, 1'b0};
      vecs[3]  = '{0, 0, 8'h00, 1, 1, 8'h6B, 1'b0};
      vecs[4]  = '{0, 0, 8'h00, 0, 1, 8'h6A, 1'b0};
      vecs[5]  = '{0, 0, 8'h00, 0, 1, 8'h69, 1'b0};
      vecs[6]  = '{0, 1, 8'hFF, 0, 0, 8'hFF, 1'b0};
      vecs[7]  = '{0, 0, 8'h00, 1, 0, 8'h00, 1'b1};
      vecs[8]  = '{0, 0, 8'h00, 0, 0, 8'h00, 1'b0};
      vecs[9]  = '{0, 0, 8'h00, 0, 1, 8'hFF, 1'b1};
      vecs[10] = '{1, 0, 8'h00, 1, 0, 8'h6A, 1'b0};

      // Reset state
      rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00;
      acrescer = 1'b0; decrecer = 1'b0;
      model_reset();
      #12;
      chk("rst_cnt", 32'(cnt_o[0]), 32'h6A);
      chk("rst_evt", 32'(evt_o[0]), 32'd0);
      chk("rst_at_max", 32'(amax_o[0]), 32'd0);
      chk("rst_at_min", 32'(amin_o[0]), 32'd0);
      check_all();
      rst_n = 1'b1;

      // Basic counting, hold, wrap in both directions, clear
      for (int k = 0; k < 11; k++) begin
         apply(vecs[k].c, vecs[k].l, vecs[k].lv, vecs[k].u, vecs[k].d);
         chk($sformatf("vec%0d_cnt", k), 32'(cnt_o[0]), 32'(vecs[k].exp_cnt));
         chk($sformatf("vec%0d_evt", k), 32'(evt_o[0]), 32'(vecs[k].exp_evt));
         if (k == 7) chk("wrap_at_min", 32'(amin_o[0]), 32'd1);
      end

      // Saturating instance clamps at the top and keeps flagging it
      apply(0, 1, 8'hFE, 0, 0);
      apply(0, 0, 8'h00, 1, 0);
      chk("sat1_cnt", 32'(cnt_o[1]), 32'hFF);
      chk("sat1_evt", 32'(evt_o[1]), 32'd0);
      apply(0, 0, 8'h00, 1, 0);
      chk("sat2_cnt", 32'(cnt_o[1]), 32'hFF);
      chk("sat2_evt", 32'(evt_o[1]), 32'd1);
      apply(0, 0, 8'h00, 1, 0);
      chk("sat3_cnt", 32'(cnt_o[1]), 32'hFF);
      chk("sat3_evt", 32'(evt_o[1]), 32'd1);
      chk("sat3_at_max", 32'(amax_o[1]), 32'd1);

      // Narrowed range 10..20, step 4
      apply(0, 1, 8'd30, 0, 0);
      chk("rng_ld_hi_cnt", 32'(cnt_o[2]), 32'd20);
      chk("rng_ld_hi_evt", 32'(evt_o[2]), 32'd1);
      apply(0, 1, 8'd18, 0, 0);
      chk("rng_ld18_cnt", 32'(cnt_o[2]), 32'd18);
      chk("rng_ld18_evt", 32'(evt_o[2]), 32'd0);
      apply(0, 0, 8'd0, 1, 0);
      chk("rng_wrap_cnt", 32'(cnt_o[2]), 32'd10);
      chk("rng_wrap_evt", 32'(evt_o[2]), 32'd1);
`ifdef UDC_STICKY_FLAGS_EN
      chk("rng_ovf_sticky", 32'(ovf_o[2]), 32'd1);
`endif
      apply(0, 1, 8'd11, 1, 0);
      chk("rng_load_wins", 32'(cnt_o[2]), 32'd11);
      apply(0, 1, 8'd3, 0, 0);
      chk("rng_ld_lo_cnt", 32'(cnt_o[2]), 32'd10);
      chk("rng_ld_lo_evt", 32'(evt_o[2]), 32'd1);
      chk("rng_ld_lo_at_min", 32'(amin_o[2]), 32'd1);

      // Asynchronous reset between edges takes effect immediately
      apply(0, 0, 8'd0, 1, 0);
      apply(0, 0, 8'd0, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", 32'(cnt_o[0]), 32'h6A);
      model_reset();
      check_all();
      #1;
      rst_n = 1'b1;

      // Clear beats a simultaneous count request and drops the stickies
      apply(0, 0, 8'd0, 0, 1);
      apply(0, 1, 8'hFF, 0, 0);
      apply(0, 0, 8'd0, 1, 0);
      apply(1, 0, 8'd0, 1, 0);
      chk("clr_up_cnt", 32'(cnt_o[0]), 32'h6A);
      chk("clr_up_evt", 32'(evt_o[0]), 32'd0);
`ifdef UDC_STICKY_FLAGS_EN
      chk("clr_ovf", 32'(ovf_o[0]), 32'd0);
      chk("clr_unf", 32'(unf_o[0]), 32'd0);
`endif

      // Randomised traffic against the model
      for (int k = 0; k < 400; k++) begin
         apply(($urandom_range(0, 31) == 0),
               ($urandom_range(0, 7) == 0),
               8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
